// File: rtl/csr_timer_pkg.sv
// rtl/csr_timer_pkg.sv - register map constants for the CSR timer
package csr_timer_pkg;

   localparam logic [2:0] REG_CTRL     = 3'd0;
   localparam logic [2:0] REG_COMPARE  = 3'd1;
   localparam logic [2:0] REG_COUNTER  = 3'd2;
   localparam logic [2:0] REG_STATUS   = 3'd3;
   localparam logic [2:0] REG_PRESCALE = 3'd4;

   localparam int CTRL_EN         = 0;
   localparam int CTRL_AUTORELOAD = 1;
   localparam int CTRL_IRQ_EN     = 2;

endpackage

// File: rtl/csr_timer_prescaler.sv
// rtl/csr_timer_prescaler.sv - 16-bit prescaler producing a one-cycle tick
module csr_timer_prescaler (
   input  logic        sys_clk,
   input  logic        sys_rst,
   input  logic        run,
   input  logic        clear,
   input  logic [15:0] div,
   output logic        tick
);

   logic [15:0] pcnt;

   // tick is combinational so that div=0 ticks on the first enabled cycle
   assign tick = run && (pcnt == div);

   // pcnt counts 0..div while running, holds while stopped, restarts on clear
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         pcnt <= '0;
      end else if (clear) begin
         pcnt <= '0;
      end else if (run) begin
         pcnt <= tick ? 16'd0 : pcnt + 16'd1;
      end
   end

endmodule

// File: rtl/csr_timer.sv
// rtl/csr_timer.sv - CSR-bus timer with prescaler, compare, auto-reload and irq
module csr_timer
   import csr_timer_pkg::*;
#(
   parameter logic [3:0] csr_addr = 4'h4
) (
   input  logic        sys_clk,
   input  logic        sys_rst,
   input  logic [13:0] csr_a,
   input  logic        csr_we,
   input  logic [31:0] csr_di,
   output logic [31:0] csr_do,
   output logic        irq
);

   logic        sel;
   logic [2:0]  idx;
   logic        wr_ctrl, wr_compare, wr_counter, wr_status, wr_prescale;
   logic        ctrl_en, ctrl_autoreload, ctrl_irq_en;
   logic [31:0] compare;
   logic [31:0] counter;
   logic        expired;
   logic [15:0] prescale;
   logic        tick;
   logic        hit;
   logic [31:0] rd_data;
   logic        unused_addr_bits;

   assign sel = (csr_a[13:10] == csr_addr);
   assign idx = csr_a[2:0];
   assign unused_addr_bits = ^csr_a[9:3];

   assign wr_ctrl     = sel && csr_we && (idx == REG_CTRL);
   assign wr_compare  = sel && csr_we && (idx == REG_COMPARE);
   assign wr_counter  = sel && csr_we && (idx == REG_COUNTER);
   assign wr_status   = sel && csr_we && (idx == REG_STATUS);
   assign wr_prescale = sel && csr_we && (idx == REG_PRESCALE);

   // expiry is judged on the pre-write counter value
   assign hit = tick && (counter == compare);

   csr_timer_prescaler u_prescaler (
      .sys_clk (sys_clk),
      .sys_rst (sys_rst),
      .run     (ctrl_en),
      .clear   (wr_ctrl && csr_di[CTRL_EN] && !ctrl_en),
      .div     (prescale),
      .tick    (tick)
   );

   // CTRL: a bus write wins over the one-shot auto-disable
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         ctrl_en         <= 1'b0;
         ctrl_autoreload <= 1'b0;
         ctrl_irq_en     <= 1'b0;
      end else if (wr_ctrl) begin
         ctrl_en         <= csr_di[CTRL_EN];
         ctrl_autoreload <= csr_di[CTRL_AUTORELOAD];
         ctrl_irq_en     <= csr_di[CTRL_IRQ_EN];
      end else if (hit && !ctrl_autoreload) begin
         ctrl_en <= 1'b0;
      end
   end

   // COMPARE and PRESCALE are plain read/write storage
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         compare  <= '0;
         prescale <= '0;
      end else begin
         if (wr_compare)  compare  <= csr_di;
         if (wr_prescale) prescale <= csr_di[15:0];
      end
   end

   // COUNTER: bus write beats tick; a match clears, otherwise wraps silently
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         counter <= '0;
      end else if (wr_counter) begin
         counter <= csr_di;
      end else if (tick) begin
         counter <= hit ? 32'd0 : counter + 32'd1;
      end
   end

   // STATUS.expired: sticky, write-1-to-clear, a new expiry beats the clear
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         expired <= 1'b0;
      end else if (hit) begin
         expired <= 1'b1;
      end else if (wr_status && csr_di[0]) begin
         expired <= 1'b0;
      end
   end

   // read mux for the addressed register
   always_comb begin
      rd_data = '0;
      case (idx)
         REG_CTRL:     rd_data = {29'd0, ctrl_irq_en, ctrl_autoreload, ctrl_en};
         REG_COMPARE:  rd_data = compare;
         REG_COUNTER:  rd_data = counter;
         REG_STATUS:   rd_data = {31'd0, expired};
         REG_PRESCALE: rd_data = {16'd0, prescale};
         default:      rd_data = '0;
      endcase
   end

   // registered read data (zero when not selected) and level interrupt
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         csr_do <= '0;
         irq    <= 1'b0;
      end else begin
         csr_do <= sel ? rd_data : 32'd0;
         irq    <= expired && ctrl_irq_en;
      end
   end

endmodule

// File: tb/tb_csr_timer.sv
// tb/tb_csr_timer.sv - randomized model-checked bench for csr_timer
module tb_csr_timer;

   logic        sys_clk;
   logic        sys_rst;
   logic [13:0] csr_a;
   logic        csr_we;
   logic [31:0] csr_di;
   logic [31:0] csr_do;
   logic        irq;

   int total;
   int bad;
   logic run_chk;

   // reference state
   logic        m_en, m_ar, m_ie, m_exp;
   logic [31:0] m_cmp, m_cnt;
   logic [15:0] m_pre, m_pcnt;
   logic [31:0] m_do;
   logic        m_irq;
   logic        m_hit_last;
   int          m_cyc;
   int          hit_q[$];

   csr_timer #(.csr_addr(4'h4)) dut (
      .sys_clk (sys_clk),
      .sys_rst (sys_rst),
      .csr_a   (csr_a),
      .csr_we  (csr_we),
      .csr_di  (csr_di),
      .csr_do  (csr_do),
      .irq     (irq)
   );

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_en = 0; m_ar = 0; m_ie = 0; m_exp = 0;
      m_cmp = 0; m_cnt = 0; m_pre = 0; m_pcnt = 0;
      m_do = 0; m_irq = 0; m_hit_last = 0;
   endtask

   // one clock of the timer, computed from the register-level rules
   task automatic model_step(input logic [13:0] a, input logic we, input logic [31:0] di);
      logic        sel, wr, tick, hit;
      logic [2:0]  idx;
      logic [31:0] rd;
      logic        n_en, n_ar, n_ie, n_exp;
      logic [31:0] n_cmp, n_cnt;
      logic [15:0] n_pre, n_pcnt;
      sel  = (a[13:10] == 4'h4);
      idx  = a[2:0];
      wr   = sel && we;
      tick = m_en && (m_pcnt == m_pre);
      hit  = tick && (m_cnt == m_cmp);
      case (idx)
         3'd0: rd = {29'd0, m_ie, m_ar, m_en};
         3'd1: rd = m_cmp;
         3'd2: rd = m_cnt;
         3'd3: rd = {31'd0, m_exp};
         3'd4: rd = {16'd0, m_pre};
         default: rd = 32'd0;
      endcase
      n_en = m_en; n_ar = m_ar; n_ie = m_ie; n_exp = m_exp;
      n_cmp = m_cmp; n_cnt = m_cnt; n_pre = m_pre;
      if (wr && idx == 3'd0 && di[0] && !m_en) n_pcnt = 0;
      else if (tick)                           n_pcnt = 0;
      else if (m_en)                           n_pcnt = m_pcnt + 16'd1;
      else                                     n_pcnt = m_pcnt;
      if (tick) n_cnt = hit ? 32'd0 : m_cnt + 32'd1;
      if (hit) begin
         n_exp = 1;
         if (!m_ar) n_en = 0;
      end
      if (wr) begin
         case (idx)
            3'd0: begin n_en = di[0]; n_ar = di[1]; n_ie = di[2]; end
            3'd1: n_cmp = di;
            3'd2: n_cnt = di;
            3'd3: if (di[0] && !hit) n_exp = 0;
            3'd4: n_pre = di[15:0];
            default: ;
         endcase
      end
      m_irq = m_exp && m_ie;
      m_do  = sel ? rd : 32'd0;
      m_en = n_en; m_ar = n_ar; m_ie = n_ie; m_exp = n_exp;
      m_cmp = n_cmp; m_cnt = n_cnt; m_pre = n_pre; m_pcnt = n_pcnt;
      m_cyc++;
      m_hit_last = hit;
      if (hit) hit_q.push_back(m_cyc);
   endtask

   function automatic logic [13:0] addr(input logic [3:0] bank, input logic [2:0] idx);
      logic [6:0] mid;
      mid = 7'($urandom);
      return {bank, mid, idx};
   endfunction

   // drive one bus cycle from a falling edge, advance model at the rising edge
   task automatic cycle(input logic [13:0] a, input logic we, input logic [31:0] di);
      csr_a = a; csr_we = we; csr_di = di;
      @(posedge sys_clk);
      model_step(a, we, di);
      @(negedge sys_clk);
      csr_we = 1'b0;
   endtask

   task automatic wr(input logic [2:0] idx, input logic [31:0] d);
      cycle(addr(4'h4, idx), 1'b1, d);
   endtask

   task automatic rd(input logic [2:0] idx);
      cycle(addr(4'h4, idx), 1'b0, 32'd0);
   endtask

   task automatic idle();
      cycle(14'd0, 1'b0, 32'd0);
   endtask

   // every cycle: registered outputs must equal the model
   always @(negedge sys_clk) begin
      if (run_chk) begin
         check("csr_do", csr_do, m_do);
         check("irq", {31'd0, irq}, {31'd0, m_irq});
      end
   end

   initial begin
      logic [31:0] seq [7];
      logic [31:0] r, r2, di;
      logic [3:0]  bank;
      logic [2:0]  idx;
      logic        we;
      int          exp_at, cyc0;
      total = 0; bad = 0; run_chk = 0; m_cyc = 0;
      seq = '{32'd0, 32'd0, 32'd0, 32'd1, 32'd1, 32'd1, 32'd0};
      sys_rst = 1'b1; csr_a = '0; csr_we = 1'b0; csr_di = '0;
      model_reset();
      repeat (3) @(negedge sys_clk);
      check("reset_do", csr_do, 32'd0);
      check("reset_irq", {31'd0, irq}, 32'd0);
      sys_rst = 1'b0;
      run_chk = 1'b1;

      // reset readback and simple write/read
      for (int i = 0; i < 8; i++) begin
         rd(3'(i));
         check("reset_read", csr_do, 32'd0);
      end
      wr(3'd1, 32'hDEADBEEF);
      rd(3'd1);
      check("compare_readback", csr_do, 32'hDEADBEEF);

      // foreign bank access
      cycle({4'h3, 7'd0, 3'd1}, 1'b1, 32'd5);
      check("bank_miss_do", csr_do, 32'd0);
      rd(3'd1);
      check("bank_miss_compare", csr_do, 32'hDEADBEEF);

      // one-shot, no prescale
      wr(3'd4, 32'd0); wr(3'd1, 32'd3); wr(3'd2, 32'd0); wr(3'd3, 32'd1);
      wr(3'd0, 32'd5);
      exp_at = 0;
      for (int k = 1; k <= 5; k++) begin
         idle();
         if (m_exp && exp_at == 0) exp_at = k;
         if (k == 4) check("oneshot_irq_low", {31'd0, irq}, 32'd0);
         if (k == 5) check("oneshot_irq_high", {31'd0, irq}, 32'd1);
      end
      check("oneshot_latency", 32'(exp_at), 32'd4);
      rd(3'd0); check("oneshot_ctrl", csr_do, 32'd4);
      rd(3'd2); check("oneshot_counter", csr_do, 32'd0);
      rd(3'd3); check("oneshot_status", csr_do, 32'd1);
      wr(3'd3, 32'd1);
      check("irq_after_clear_write", {31'd0, irq}, 32'd1);
      idle();
      check("irq_dropped", {31'd0, irq}, 32'd0);

      // prescaled auto-reload
      wr(3'd0, 32'd0); wr(3'd4, 32'd2); wr(3'd1, 32'd1); wr(3'd2, 32'd0); wr(3'd3, 32'd1);
      hit_q.delete();
      wr(3'd0, 32'd3);
      cyc0 = m_cyc;
      for (int i = 0; i < 7; i++) begin
         rd(3'd2);
         check("reload_counter_seq", csr_do, seq[i]);
      end
      repeat (6) idle();
      check("reload_hits", 32'(hit_q.size()), 32'd2);
      if (hit_q.size() >= 2) begin
         check("reload_first", 32'(hit_q[0] - cyc0), 32'd6);
         check("reload_second", 32'(hit_q[1] - cyc0), 32'd12);
      end

      // collisions
      wr(3'd0, 32'd0); wr(3'd4, 32'd0); wr(3'd1, 32'd2); wr(3'd2, 32'd0); wr(3'd3, 32'd1);
      wr(3'd0, 32'd3);
      idle(); idle();
      wr(3'd3, 32'd1);
      check("collide_hit_cycle", {31'd0, m_hit_last}, 32'd1);
      rd(3'd3); check("collide_status", csr_do, 32'd1);
      wr(3'd2, 32'd7);
      rd(3'd2); check("collide_counter_write", csr_do, 32'd7);

      // asynchronous reset mid-count
      wr(3'd0, 32'd0); wr(3'd4, 32'd3); wr(3'd1, 32'd100); wr(3'd2, 32'd0); wr(3'd3, 32'd1);
      wr(3'd0, 32'd7);
      repeat (8) idle();
      rd(3'd2);
      check("pre_reset_count", m_cnt, 32'd2);
      check("pre_reset_do", csr_do, 32'd2);
      #2;
      sys_rst = 1'b1;
      model_reset();
      #1;
      check("async_rst_do", csr_do, 32'd0);
      check("async_rst_irq", {31'd0, irq}, 32'd0);
      check("async_rst_counter", dut.counter, 32'd0);
      check("async_rst_en", {31'd0, dut.ctrl_en}, 32'd0);
      @(posedge sys_clk);
      @(negedge sys_clk);
      sys_rst = 1'b0;
      rd(3'd2); check("post_reset_counter", csr_do, 32'd0);
      rd(3'd0); check("post_reset_ctrl", csr_do, 32'd0);

      // randomized traffic
      for (int n = 0; n < 3000; n++) begin
         r  = $urandom;
         r2 = $urandom;
         bank = (r[3:0] < 4'd13) ? 4'h4 : r[7:4];
         idx  = r[10:8];
         we   = (r[12:11] != 2'b00);
         case (idx)
            3'd1: di = {28'd0, r2[3:0]};
            3'd2: di = r2[8] ? (32'hFFFFFFFC + {30'd0, r2[1:0]}) : {28'd0, r2[3:0]};
            3'd4: di = {r2[31:16], 14'd0, r2[1:0]};
            default: di = r2;
         endcase
         cycle(addr(bank, idx), we, di);
      end

      run_chk = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
